// File: rtl/irq_encoder_pkg.sv
// Shared constants, FSM state type and index helper for the 16-to-4 interrupt encoder.
package irq_encoder_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return N_REQ'(1) << i;
    endfunction

endpackage

// File: rtl/prio_enc_16_4.sv
// Combinational 16-to-4 priority encoder; idx is 0 when no bit is set.
module prio_enc_16_4
    import irq_encoder_pkg::*;
#(
    parameter bit PRIORITY_LSB = 1'b1
) (
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // The loop order makes the last match win, so scan from the lowest-priority end.
    always_comb begin
        idx = '0;
        any = |vec;
        if (PRIORITY_LSB) begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_encoder_16_4.sv
// Registered 16-to-4 priority encoder with pending register and valid/ack handshake.
//   state    | meaning
//   ST_IDLE  | no live grant; grants the best eligible pending bit when enabled
//   ST_GRANT | valid=1, idx held until ack (clear bit) or enable drop (withdraw)
module irq_encoder_16_4
    import irq_encoder_pkg::*;
#(
    parameter bit PRIORITY_LSB = 1'b1,
    parameter bit EDGE_MODE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             ack,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic [N_REQ-1:0] pending,
    output logic             multi
);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx_d;
    logic [N_REQ-1:0] req_d;
    logic [N_REQ-1:0] set, clr, elig;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;

    assign set   = EDGE_MODE ? (req & ~req_d) : req;
    assign clr   = (state == ST_GRANT && ack) ? onehot(idx) : '0;
    assign elig  = pending & ~mask;
    assign valid = (state == ST_GRANT);
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = enc_any && ((elig & (elig - N_REQ'(1))) != '0);

    prio_enc_16_4 #(
        .PRIORITY_LSB(PRIORITY_LSB)
    ) u_prio (
        .vec(elig),
        .idx(enc_idx),
        .any(enc_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            idx     <= '0;
            req_d   <= '0;
            pending <= '0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            req_d   <= req;
            pending <= (pending & ~clr) | set;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        case (state)
            ST_IDLE: begin
                if (enable && enc_any) begin
                    idx_d   = enc_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (ack || !enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
